// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands bit-serially, LSB first,
//   using one full_adder cell and a carry flip-flop. Start is taken only in
//   IDLE; the result appears WIDTH cycles later with a one-cycle done pulse.
// Latency: start sampled at edge E0 -> done high from E0+WIDTH to E0+WIDTH+1.
//   Minimum issue period is WIDTH+2 cycles.
// Backpressure: none; start during RUN or DONE is dropped, not queued.
// Ports: clk, rst_n (async active-low); start, a, b, cin in;
//   busy, done, sum, cout, ovf out.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
//   output ovf. Without it, the ovf port and its logic are absent.

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_s_sh;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             r_ovf;
`endif

   logic             w_fa_sum;
   logic             w_fa_cout;
   logic             w_last_bit;

   full_adder u_fa (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_cin  (r_carry),
      .o_sum  (w_fa_sum),
      .o_cout (w_fa_cout)
   );

   // The MSB is being added when the counter reaches WIDTH-1.
   assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last_bit) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand shifters, partial-sum shifter, carry, counter, result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_s_sh  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               // Sum bits enter at the top so the LSB ends up at bit 0.
               r_s_sh  <= {w_fa_sum, r_s_sh[WIDTH-1:1]};
               r_carry <= w_fa_cout;
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last_bit) begin
                  r_sum  <= {w_fa_sum, r_s_sh[WIDTH-1:1]};
                  r_cout <= w_fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                  // r_carry is the carry into the MSB during this cycle.
                  r_ovf  <= r_carry ^ w_fa_cout;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: exercises serial_adder_ctrl with directed and random
//   operands; expected results are queued at issue time and popped by a
//   monitor when done is expected.
// Timing: inputs change 2 time units after the rising edge, outputs sampled
//   on the falling edge.

module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           due;
   } exp_t;

   exp_t sb[$];
   int   vec = 0;
   int   miss = 0;
   int   cyc = 0;
   int   last_e0 = -100;
   int   next_free = 0;

   logic [W-1:0] held_sum = '0;
   logic         held_cout = 1'b0;
   logic         held_ovf = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: an idle adder accepts start, result is plain a+b+cin.
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         sb.delete();
         last_e0   = -100;
         next_free = 0;
      end else if (start && cyc >= next_free) begin
         exp_t e;
         int   tot;
         int   ssum;
         tot   = int'(a) + int'(b) + int'(cin);
         ssum  = int'($signed(a)) + int'($signed(b)) + int'(cin);
         e.sum  = tot[W-1:0];
         e.cout = tot[W];
         e.ovf  = (ssum > 127 || ssum < -128);
         e.due  = cyc + W;
         sb.push_back(e);
         last_e0   = cyc;
         next_free = cyc + W + 2;
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         held_sum  = '0;
         held_cout = 1'b0;
         held_ovf  = 1'b0;
      end else begin
         logic exp_busy;
         logic exp_done;
         exp_busy = (cyc >= last_e0) && (cyc < last_e0 + W);
         exp_done = (sb.size() > 0) && (sb[0].due == cyc);
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("done", 32'(done), 32'(exp_done));
         if (exp_done) begin
            exp_t e;
            e = sb.pop_front();
            held_sum  = e.sum;
            held_cout = e.cout;
            held_ovf  = e.ovf;
         end
         chk("sum", 32'(sum), 32'(held_sum));
         chk("cout", 32'(cout), 32'(held_cout));
`ifdef SERIAL_ADD_OVF_EN
         chk("ovf", 32'(ovf), 32'(held_ovf));
`endif
      end
   end

   task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic c);
      @(posedge clk);
      #2;
      start = s;
      a     = av;
      b     = bv;
      cin   = c;
   endtask

   task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
      drive(1'b1, av, bv, c);
      for (int k = 1; k <= W + 1; k++) drive(1'b0, '0, '0, 1'b0);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_done"}, 32'(done), 32'd0);
      chk({nm, "_sum"}, 32'(sum), 32'd0);
      chk({nm, "_cout"}, 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk({nm, "_ovf"}, 32'(ovf), 32'd0);
`endif
   endtask

   initial begin
      #3;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Directed results
      op(8'hFF, 8'h01, 1'b0);
      op(8'h55, 8'hAA, 1'b1);
      op(8'h12, 8'h34, 1'b0);
      repeat (5) drive(1'b0, '0, '0, 1'b0);

      // Re-pulse start in RUN (k=3) and in DONE (k=W+1): both must be dropped
      drive(1'b1, 8'h12, 8'h34, 1'b0);
      for (int k = 1; k <= W + 1; k++)
         drive((k == 3 || k == W + 1), 8'h01, 8'h01, 1'b0);
      repeat (3) drive(1'b0, '0, '0, 1'b0);

      // Start held high: a result every W+2 cycles
      repeat (40) drive(1'b1, 8'h3C, 8'hC5, 1'b1);
      repeat (W + 3) drive(1'b0, '0, '0, 1'b0);

      // Reset in RUN cycle 4 aborts the operation
      drive(1'b1, 8'h0F, 8'h0F, 1'b0);
      repeat (4) drive(1'b0, '0, '0, 1'b0);
      #1 rst_n = 1'b0;
      #1 check_zero("abort");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      op(8'hA0, 8'h0B, 1'b1);

      // Signed-overflow corners
      op(8'h7F, 8'h01, 1'b0);
      op(8'hFF, 8'h01, 1'b0);
      op(8'h80, 8'h80, 1'b0);
      op(8'h7F, 8'h00, 1'b1);

      // Random traffic, start often asserted while busy
      for (int i = 0; i < 6000; i++)
         drive(($urandom_range(3, 0) != 0), W'($urandom), W'($urandom), 1'($urandom));

      repeat (W + 4) drive(1'b0, '0, '0, 1'b0);
      chk("pending_results", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
